// File: rtl/dpwm_pkg.sv
// Shared encodings and reset defaults for the DPWM timebase.
package dpwm_pkg;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int unsigned DEF_PERIOD = 1000;
  localparam int unsigned DEF_STEP   = 50;

endpackage

// File: rtl/dpwm_compare_ch.sv
// One PWM compare channel: duty shadow/active pair and registered comparator.
module dpwm_compare_ch #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             load_shadow,
  input  logic [WIDTH-1:0] shadow_data,
  input  logic             boundary,
  input  logic [WIDTH-1:0] cuenta,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] active_q;

  // Shadow takes writes any time; active copies the pre-write shadow at the boundary.
  always_ff @(posedge CLK) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm      <= 1'b0;
    end else begin
      if (load_shadow) shadow_q <= shadow_data;
      if (boundary)    active_q <= shadow_q;
      if (en)          pwm      <= (cuenta < active_q);
    end
  end

endmodule

// File: rtl/dpwm_counter_multi.sv
// Multi-channel DPWM timebase: sawtooth/triangle counter with boundary-buffered config.
module dpwm_counter_multi
  import dpwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DEF_PERIOD = dpwm_pkg::DEF_PERIOD,
  parameter int unsigned DEF_STEP   = dpwm_pkg::DEF_STEP
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic [WIDTH-1:0]    period,
  input  logic [WIDTH-1:0]    step,
  input  logic                duty_wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_sel,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [WIDTH-1:0]    cuenta,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                wrap
);

  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW    = WIDTH + 1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q;
  logic [WIDTH-1:0] stp_q;
  logic             mode_q;
  dir_t             dir_q, dir_d;
  logic [AW-1:0]    sum_c;
  logic             bnd_c;

  assign sum_c = {1'b0, cnt_q} + {1'b0, stp_q};

  // Counter next-state and direction FSM.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    bnd_c = 1'b0;
    if (en) begin
      if (mode_q == MODE_SAW) begin
        if (cnt_q >= per_q) begin
          cnt_d = '0;
          bnd_c = 1'b1;
        end else begin
          cnt_d = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
        end
      end else if (per_q == '0) begin
        cnt_d = '0;
        bnd_c = 1'b1;
      end else begin
        case (dir_q)
          DIR_UP: begin
            if (sum_c >= {1'b0, per_q}) begin
              cnt_d = per_q;
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = sum_c[WIDTH-1:0];
            end
          end
          default: begin
            if (cnt_q <= stp_q) begin
              cnt_d = '0;
              dir_d = DIR_UP;
              bnd_c = 1'b1;
            end else begin
              cnt_d = cnt_q - stp_q;
            end
          end
        endcase
      end
      if (bnd_c) dir_d = DIR_UP;
    end
  end

  // Counter, direction, active config and wrap pulse registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      per_q  <= WIDTH'(DEF_PERIOD);
      stp_q  <= WIDTH'(DEF_STEP);
      mode_q <= MODE_SAW;
      wrap   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      wrap  <= bnd_c;
      if (bnd_c) begin
        per_q  <= period;
        stp_q  <= step;
        mode_q <= mode;
      end
    end
  end

  assign cuenta = cnt_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dpwm_compare_ch #(.WIDTH(WIDTH)) u_ch (
      .CLK         (CLK),
      .reset       (reset),
      .en          (en),
      .load_shadow (duty_wr && (duty_sel == SEL_W'(i))),
      .shadow_data (duty_data),
      .boundary    (bnd_c),
      .cuenta      (cnt_q),
      .pwm         (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_dpwm_counter_multi.sv
// Self-checking bench for dpwm_counter_multi against a cycle-level behavioural model.
module tb_dpwm_counter_multi;

  localparam int MAXV = 1023;

  logic       CLK = 1'b0;
  logic       reset, en, mode, duty_wr;
  logic [9:0] period, step, duty_data;
  logic [1:0] duty_sel;
  logic [9:0] cuenta;
  logic [3:0] pwm_out;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int       m_cnt, m_per, m_stp;
  bit       m_up, m_mode, m_wrap;
  int       m_duty[4];
  int       m_sh[4];
  logic [3:0] m_pwm;

  dpwm_counter_multi dut (
    .CLK(CLK), .reset(reset), .en(en), .mode(mode), .period(period), .step(step),
    .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
    .cuenta(cuenta), .pwm_out(pwm_out), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    int  old_sh[4];
    int  nc;
    bit  b;
    bit  nup;
    if (reset) begin
      m_cnt = 0; m_up = 1; m_per = 1000; m_stp = 50; m_mode = 0;
      m_wrap = 0; m_pwm = '0;
      for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
      return;
    end
    old_sh = m_sh;
    if (duty_wr) m_sh[duty_sel] = int'(duty_data);
    b = 0; nc = m_cnt; nup = m_up;
    if (en) begin
      for (int i = 0; i < 4; i++) m_pwm[i] = (m_cnt < m_duty[i]);
      if (!m_mode) begin
        if (m_cnt >= m_per) begin nc = 0; b = 1; end
        else nc = (m_cnt + m_stp > MAXV) ? MAXV : m_cnt + m_stp;
      end else if (m_per == 0) begin
        nc = 0; b = 1;
      end else if (m_up) begin
        if (m_cnt + m_stp >= m_per) begin nc = m_per; nup = 0; end
        else nc = m_cnt + m_stp;
      end else begin
        if (m_cnt <= m_stp) begin nc = 0; b = 1; end
        else nc = m_cnt - m_stp;
      end
      if (b) begin
        m_per = int'(period); m_stp = int'(step); m_mode = mode;
        m_duty = old_sh; nup = 1;
      end
    end
    m_wrap = b; m_cnt = nc; m_up = nup;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK); #1;
    check("cuenta", 32'(cuenta), 32'(m_cnt));
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("wrap", 32'(wrap), 32'(m_wrap));
    duty_wr = 1'b0;
  endtask

  task automatic wait_wrap(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (wrap) seen = 1;
    end
    check("wrap_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic run_to(input int target, input int budget);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      tick();
      if (int'(cuenta) == target) hit = 1;
    end
    check("reach_count", 32'(hit), 32'd1);
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_wr = 1'b1; duty_sel = 2'(ch); duty_data = 10'(val);
    tick();
  endtask

  initial begin
    int wraps, highs, n;
    int tri_exp[9];
    int sat_exp[4];
    tri_exp = '{0, 30, 60, 90, 100, 70, 40, 10, 0};
    sat_exp = '{0, 1000, 1023, 0};

    reset = 1; en = 0; mode = 0; period = 10'd1000; step = 10'd50;
    duty_wr = 0; duty_sel = 0; duty_data = 0;
    tick(); tick();
    check("reset_cuenta", 32'(cuenta), 32'd0);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    reset = 0;

    // Default sawtooth
    en = 1; wraps = 0;
    repeat (42) begin tick(); wraps += int'(wrap); end
    check("wrap_count_42", 32'(wraps), 32'd2);

    // Duty shadowing on ch0
    repeat (5) tick();
    write_duty(0, 500);
    wait_wrap(30);
    highs = 0;
    repeat (21) begin tick(); highs += int'(pwm_out[0]); end
    check("ch0_high_cycles", 32'(highs), 32'd10);

    // Triangle
    mode = 1; period = 10'd100; step = 10'd30;
    wait_wrap(30);
    check("tri_seq_0", 32'(cuenta), 32'(tri_exp[0]));
    for (int k = 1; k < 9; k++) begin
      tick();
      check("tri_seq", 32'(cuenta), 32'(tri_exp[k]));
    end
    check("tri_wrap_at_zero", 32'(wrap), 32'd1);

    // Edge duties
    mode = 0; period = 10'd1000; step = 10'd50;
    wait_wrap(30);
    write_duty(1, 0);
    write_duty(2, 1023);
    wait_wrap(30);
    tick();
    repeat (25) begin
      tick();
      check("ch1_const0", 32'(pwm_out[1]), 32'd0);
      check("ch2_const1", 32'(pwm_out[2]), 32'd1);
    end

    // Enable hold and reset mid-run
    run_to(350, 40);
    en = 0;
    repeat (5) tick();
    check("hold_cuenta", 32'(cuenta), 32'd350);
    check("hold_wrap", 32'(wrap), 32'd0);
    en = 1;
    run_to(600, 40);
    reset = 1;
    tick();
    check("rst_cuenta", 32'(cuenta), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    reset = 0; period = 10'd200;
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      tick();
      if (wrap) n = k;
    end
    check("post_reset_period", 32'(n), 32'd21);

    // Saturation, then step=0
    period = 10'd1023; step = 10'd1000;
    wait_wrap(40);
    check("sat_seq_0", 32'(cuenta), 32'(sat_exp[0]));
    for (int k = 1; k < 4; k++) begin
      tick();
      check("sat_seq", 32'(cuenta), 32'(sat_exp[k]));
    end
    step = 10'd0;
    wait_wrap(5);
    repeat (10) begin
      tick();
      check("step0_hold", 32'(cuenta), 32'd0);
      check("step0_nowrap", 32'(wrap), 32'd0);
    end

    // Randomised run
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) begin
        mode   = 1'($urandom_range(0, 1));
        period = 10'($urandom_range(0, 1023));
        step   = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 5) == 0) begin
        duty_wr = 1; duty_sel = 2'($urandom_range(0, 3));
        duty_data = 10'($urandom_range(0, 1023));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
